// File: rtl/decode_rename.sv
// Decode-and-rename stage: classifies one RV32IM instruction per cycle, renames its
// registers through a speculative RAT, and restores from the committed RAT on flush.
module decode_rename #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int PREG_W    = 6
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [31:0]       pc_i,
  input  logic              inst_valid_i,
  input  logic [31:0]       inst_i,
  output logic              inst_ready_o,
  input  logic              cdb_en_i,
  input  logic [PREG_W-1:0] cdb_preg_i,
  input  logic              commit_en_i,
  input  logic [4:0]        commit_rd_i,
  input  logic [PREG_W-1:0] commit_prd_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_pc_o,
  output logic [31:0]       out_inst_o,
  output logic              out_alu_o,
  output logic              out_lsu_o,
  output logic              out_mul_o,
  output logic              out_br_o,
  output logic              out_illegal_o,
  output logic [PREG_W-1:0] out_prs1_o,
  output logic [PREG_W-1:0] out_prs2_o,
  output logic              out_prs1_ready_o,
  output logic              out_prs2_ready_o,
  output logic              out_wr_o,
  output logic [PREG_W-1:0] out_prd_o,
  output logic [PREG_W-1:0] out_prd_old_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  function automatic logic [PHYS_REGS-1:0] free_init();
    logic [PHYS_REGS-1:0] v;
    for (int i = 0; i < PHYS_REGS; i++) v[i] = (i >= ARCH_REGS);
    return v;
  endfunction

  logic [PREG_W-1:0]    spec_rat_q [ARCH_REGS];
  logic [PREG_W-1:0]    spec_rat_d [ARCH_REGS];
  logic [PREG_W-1:0]    crat_q     [ARCH_REGS];
  logic [PREG_W-1:0]    crat_d     [ARCH_REGS];
  logic [PHYS_REGS-1:0] free_q, free_d;
  logic [PHYS_REGS-1:0] busy_q, busy_d;

  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_pc_q, out_pc_d, out_inst_q, out_inst_d;
  logic              alu_q, alu_d, lsu_q, lsu_d, mul_q, mul_d, br_q, br_d, ill_q, ill_d;
  logic [PREG_W-1:0] prs1_q, prs1_d, prs2_q, prs2_d;
  logic              rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic              wr_q, wr_d;
  logic [PREG_W-1:0] prd_q, prd_d, prd_old_q, prd_old_d;

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic       is_alu, is_lsu, is_mul, is_br, is_ill, wr;
  logic       unused_funct3;

  assign opcode        = inst_i[6:0];
  assign rd            = inst_i[11:7];
  assign rs1           = inst_i[19:15];
  assign rs2           = inst_i[24:20];
  assign unused_funct3 = ^inst_i[14:12];

  always_comb begin
    is_alu = 1'b0;
    is_lsu = 1'b0;
    is_mul = 1'b0;
    is_br  = 1'b0;
    is_ill = 1'b0;
    case (opcode)
      OP_LOAD, OP_STORE:            is_lsu = 1'b1;
      OP_OP: begin
        if (inst_i[31:25] == 7'b0000001) is_mul = 1'b1;
        else                             is_alu = 1'b1;
      end
      OP_IMM, OP_LUI, OP_AUIPC:     is_alu = 1'b1;
      OP_BRANCH, OP_JAL, OP_JALR:   is_br  = 1'b1;
      default:                      is_ill = 1'b1;
    endcase
  end

  assign wr = (rd != 5'd0) && !is_ill && (opcode != OP_STORE) && (opcode != OP_BRANCH);

  // Lowest free preg: the descending scan leaves the smallest set index in alloc_preg.
  logic [PREG_W-1:0] alloc_preg;
  logic              alloc_found;
  always_comb begin
    alloc_preg  = '0;
    alloc_found = 1'b0;
    for (int i = PHYS_REGS - 1; i >= 0; i--) begin
      if (free_q[i]) begin
        alloc_preg  = PREG_W'(i);
        alloc_found = 1'b1;
      end
    end
  end

  logic [PREG_W-1:0] prs1, prs2;
  logic              prs1_rdy, prs2_rdy, accept, do_alloc;

  assign prs1         = spec_rat_q[rs1];
  assign prs2         = spec_rat_q[rs2];
  assign prs1_rdy     = !busy_q[prs1] || (cdb_en_i && cdb_preg_i == prs1);
  assign prs2_rdy     = !busy_q[prs2] || (cdb_en_i && cdb_preg_i == prs2);
  assign inst_ready_o = !flush_i && (!out_valid_q || out_ready_i) && (!wr || alloc_found);
  assign accept       = inst_valid_i && inst_ready_o;
  assign do_alloc     = accept && wr;

  // Rename state: allocation, then wakeup, then commit, with flush rebuilding from the
  // post-commit committed RAT so a same-cycle retirement is not lost.
  always_comb begin
    spec_rat_d = spec_rat_q;
    crat_d     = crat_q;
    free_d     = free_q;
    busy_d     = busy_q;
    if (do_alloc) begin
      spec_rat_d[rd]     = alloc_preg;
      free_d[alloc_preg] = 1'b0;
      busy_d[alloc_preg] = 1'b1;
    end
    if (cdb_en_i) busy_d[cdb_preg_i] = 1'b0;
    if (commit_en_i && commit_rd_i != 5'd0) begin
      free_d[crat_q[commit_rd_i]] = 1'b1;
      crat_d[commit_rd_i]         = commit_prd_i;
    end
    if (flush_i) begin
      spec_rat_d = crat_d;
      busy_d     = '0;
      free_d     = '1;
      for (int i = 0; i < ARCH_REGS; i++) free_d[crat_d[i]] = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    alu_d       = alu_q;
    lsu_d       = lsu_q;
    mul_d       = mul_q;
    br_d        = br_q;
    ill_d       = ill_q;
    prs1_d      = prs1_q;
    prs2_d      = prs2_q;
    rdy1_d      = rdy1_q;
    rdy2_d      = rdy2_q;
    wr_d        = wr_q;
    prd_d       = prd_q;
    prd_old_d   = prd_old_q;
    if (flush_i) begin
      out_valid_d = 1'b0;
    end else if (out_valid_q && !out_ready_i) begin
      if (cdb_en_i && cdb_preg_i == prs1_q) rdy1_d = 1'b1;
      if (cdb_en_i && cdb_preg_i == prs2_q) rdy2_d = 1'b1;
    end else begin
      out_valid_d = accept;
      if (accept) begin
        out_pc_d   = pc_i;
        out_inst_d = inst_i;
        alu_d      = is_alu;
        lsu_d      = is_lsu;
        mul_d      = is_mul;
        br_d       = is_br;
        ill_d      = is_ill;
        prs1_d     = prs1;
        prs2_d     = prs2;
        rdy1_d     = prs1_rdy;
        rdy2_d     = prs2_rdy;
        wr_d       = wr;
        prd_d      = wr ? alloc_preg : '0;
        prd_old_d  = wr ? spec_rat_q[rd] : '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < ARCH_REGS; i++) begin
        spec_rat_q[i] <= PREG_W'(i);
        crat_q[i]     <= PREG_W'(i);
      end
      free_q      <= free_init();
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
      alu_q       <= 1'b0;
      lsu_q       <= 1'b0;
      mul_q       <= 1'b0;
      br_q        <= 1'b0;
      ill_q       <= 1'b0;
      prs1_q      <= '0;
      prs2_q      <= '0;
      rdy1_q      <= 1'b0;
      rdy2_q      <= 1'b0;
      wr_q        <= 1'b0;
      prd_q       <= '0;
      prd_old_q   <= '0;
    end else begin
      spec_rat_q  <= spec_rat_d;
      crat_q      <= crat_d;
      free_q      <= free_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      alu_q       <= alu_d;
      lsu_q       <= lsu_d;
      mul_q       <= mul_d;
      br_q        <= br_d;
      ill_q       <= ill_d;
      prs1_q      <= prs1_d;
      prs2_q      <= prs2_d;
      rdy1_q      <= rdy1_d;
      rdy2_q      <= rdy2_d;
      wr_q        <= wr_d;
      prd_q       <= prd_d;
      prd_old_q   <= prd_old_d;
    end
  end

  assign out_valid_o      = out_valid_q;
  assign out_pc_o         = out_pc_q;
  assign out_inst_o       = out_inst_q;
  assign out_alu_o        = alu_q;
  assign out_lsu_o        = lsu_q;
  assign out_mul_o        = mul_q;
  assign out_br_o         = br_q;
  assign out_illegal_o    = ill_q;
  assign out_prs1_o       = prs1_q;
  assign out_prs2_o       = prs2_q;
  assign out_prs1_ready_o = rdy1_q;
  assign out_prs2_ready_o = rdy2_q;
  assign out_wr_o         = wr_q;
  assign out_prd_o        = prd_q;
  assign out_prd_old_o    = prd_old_q;

endmodule

// File: tb/tb_decode_rename.sv
// Directed bench for decode_rename with hand-computed rename and classification results.
module tb_decode_rename;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] pc_i;
  logic        inst_valid_i;
  logic [31:0] inst_i;
  logic        inst_ready_o;
  logic        cdb_en_i;
  logic [5:0]  cdb_preg_i;
  logic        commit_en_i;
  logic [4:0]  commit_rd_i;
  logic [5:0]  commit_prd_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;
  logic        out_alu_o, out_lsu_o, out_mul_o, out_br_o, out_illegal_o;
  logic [5:0]  out_prs1_o, out_prs2_o;
  logic        out_prs1_ready_o, out_prs2_ready_o;
  logic        out_wr_o;
  logic [5:0]  out_prd_o, out_prd_old_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  decode_rename #(.ARCH_REGS(32), .PHYS_REGS(64), .PREG_W(6)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .pc_i(pc_i), .inst_valid_i(inst_valid_i),
    .inst_i(inst_i), .inst_ready_o(inst_ready_o), .cdb_en_i(cdb_en_i),
    .cdb_preg_i(cdb_preg_i), .commit_en_i(commit_en_i), .commit_rd_i(commit_rd_i),
    .commit_prd_i(commit_prd_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
    .out_alu_o(out_alu_o), .out_lsu_o(out_lsu_o), .out_mul_o(out_mul_o),
    .out_br_o(out_br_o), .out_illegal_o(out_illegal_o), .out_prs1_o(out_prs1_o),
    .out_prs2_o(out_prs2_o), .out_prs1_ready_o(out_prs1_ready_o),
    .out_prs2_ready_o(out_prs2_ready_o), .out_wr_o(out_wr_o), .out_prd_o(out_prd_o),
    .out_prd_old_o(out_prd_old_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic [31:0] inst, input logic [31:0] pc);
    inst_valid_i = 1'b1;
    inst_i       = inst;
    pc_i         = pc;
  endtask

  task automatic idle();
    inst_valid_i = 1'b0;
    inst_i       = 32'h0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    idle();
    tick();
    tick();
    reset_i = 1'b0;
    #1;
  endtask

  // Class bits packed as {alu,lsu,mul,br,illegal,wr}
  function automatic logic [31:0] cls();
    return {26'd0, out_alu_o, out_lsu_o, out_mul_o, out_br_o, out_illegal_o, out_wr_o};
  endfunction

  initial begin
    reset_i = 1'b1; pc_i = 0; inst_valid_i = 0; inst_i = 0; cdb_en_i = 0; cdb_preg_i = 0;
    commit_en_i = 0; commit_rd_i = 0; commit_prd_i = 0; flush_i = 0; out_ready_i = 1;

    // Reset state
    do_reset();
    chk("rst_valid", out_valid_o, 0);
    chk("rst_prd", out_prd_o, 0);
    chk("rst_ready", inst_ready_o, 1);

    // add x3,x1,x2
    offer(32'h002081B3, 32'h100);
    #1 chk("add_inrdy", inst_ready_o, 1);
    tick(); idle();
    chk("add_valid", out_valid_o, 1);
    chk("add_cls", cls(), 32'b100001);
    chk("add_prs1", out_prs1_o, 1);
    chk("add_prs2", out_prs2_o, 2);
    chk("add_rdy", {out_prs1_ready_o, out_prs2_ready_o}, 2'b11);
    chk("add_prd", out_prd_o, 32);
    chk("add_prdold", out_prd_old_o, 3);
    chk("add_pc", out_pc_o, 32'h100);
    tick();
    chk("add_drain", out_valid_o, 0);

    // Back-to-back dependency and wakeup during stall
    do_reset();
    offer(32'h00100293, 32'h200);  // addi x5,x0,1
    tick();
    chk("dep_addi_prd", out_prd_o, 32);
    chk("dep_addi_prs1rdy", out_prs1_ready_o, 1);
    offer(32'h00528333, 32'h204);  // add x6,x5,x5
    tick(); idle();
    out_ready_i = 1'b0;
    chk("dep_prs", {out_prs1_o, out_prs2_o}, {6'd32, 6'd32});
    chk("dep_rdy0", {out_prs1_ready_o, out_prs2_ready_o}, 2'b00);
    chk("dep_prd", out_prd_o, 33);
    chk("dep_prdold", out_prd_old_o, 6);
    offer(32'h00100393, 32'h208);
    #1 chk("dep_stall_inrdy", inst_ready_o, 0);
    idle();
    tick();
    chk("dep_hold_valid", out_valid_o, 1);
    chk("dep_hold_rdy", {out_prs1_ready_o, out_prs2_ready_o}, 2'b00);
    cdb_en_i = 1'b1; cdb_preg_i = 6'd32;
    tick();
    cdb_en_i = 1'b0;
    chk("dep_wake_rdy", {out_prs1_ready_o, out_prs2_ready_o}, 2'b11);
    chk("dep_wake_prd", out_prd_o, 33);
    chk("dep_wake_inst", out_inst_o, 32'h00528333);
    out_ready_i = 1'b1;
    tick();

    // Exhaust the free list
    do_reset();
    for (int k = 0; k < 32; k++) begin
      offer(32'h00100293, 32'h300 + 4 * k);
      tick();
      chk($sformatf("exh_prd%0d", k), out_prd_o, 32 + k);
    end
    #1 chk("exh_full_inrdy", inst_ready_o, 0);
    tick();
    chk("exh_full_novalid", out_valid_o, 0);
    offer(32'h0020A023, 32'h400);  // sw x2,0(x1)
    #1 chk("exh_sw_inrdy", inst_ready_o, 1);
    tick(); idle();
    chk("exh_sw_cls", cls(), 32'b010000);
    chk("exh_sw_prd", out_prd_o, 0);
    commit_en_i = 1'b1; commit_rd_i = 5'd1; commit_prd_i = 6'd32;
    tick();
    commit_en_i = 1'b0;
    offer(32'h00100293, 32'h404);
    #1 chk("exh_freed_inrdy", inst_ready_o, 1);
    tick(); idle();
    chk("exh_freed_prd", out_prd_o, 1);
    chk("exh_freed_prdold", out_prd_old_o, 63);

    // Flush after three speculative writes to x1
    do_reset();
    for (int k = 0; k < 3; k++) begin
      offer(32'h00108093, 32'h500 + 4 * k);  // addi x1,x1,1
      tick();
      chk($sformatf("fl_prd%0d", k), out_prd_o, 32 + k);
    end
    chk("fl_prs1_last", out_prs1_o, 33);
    idle();
    flush_i = 1'b1;
    #1 chk("fl_inrdy", inst_ready_o, 0);
    tick();
    flush_i = 1'b0;
    chk("fl_valid", out_valid_o, 0);
    offer(32'h001083B3, 32'h600);  // add x7,x1,x1
    tick(); idle();
    chk("fl_prs1", out_prs1_o, 1);
    chk("fl_prs1rdy", out_prs1_ready_o, 1);
    chk("fl_prd", out_prd_o, 32);
    chk("fl_prdold", out_prd_old_o, 7);

    // Classification
    do_reset();
    offer(32'h02208033, 32'h700);  // mul x0,x1,x2
    tick();
    chk("cls_mul", cls(), 32'b001000);
    chk("cls_mul_prd", out_prd_o, 0);
    offer(32'h0000A083, 32'h704);  // lw x1,0(x1)
    tick();
    chk("cls_lw", cls(), 32'b010001);
    chk("cls_lw_prd", out_prd_o, 32);
    offer(32'h00208063, 32'h708);  // beq
    tick();
    chk("cls_beq", cls(), 32'b000100);
    offer(32'hFFFFFFFF, 32'h70C);
    tick();
    chk("cls_ill", cls(), 32'b000010);
    chk("cls_ill_inst", out_inst_o, 32'hFFFFFFFF);
    chk("cls_ill_pc", out_pc_o, 32'h70C);
    offer(32'h0040006F, 32'h710);  // jal x0
    tick(); idle();
    chk("cls_jal", cls(), 32'b000100);

    // Asynchronous reset while output valid
    do_reset();
    offer(32'h00100293, 32'h800);
    tick(); idle();
    chk("ar_valid_before", out_valid_o, 1);
    #2 reset_i = 1'b1;
    #1;
    chk("ar_valid", out_valid_o, 0);
    chk("ar_prd", out_prd_o, 0);
    chk("ar_cls", cls(), 0);
    reset_i = 1'b0;
    tick();
    offer(32'h002081B3, 32'h900);
    tick(); idle();
    chk("ar_post_prs", {out_prs1_o, out_prs2_o}, {6'd1, 6'd2});
    chk("ar_post_prd", out_prd_o, 32);
    chk("ar_post_prdold", out_prd_old_o, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
